// File: rtl/traffic_light_pkg.sv
// rtl/traffic_light_pkg.sv - light codes, sensor bit positions and phase states shared by light controllers
package traffic_light_pkg;

  typedef enum logic [2:0] {
    LIGHT_STOP         = 3'b000,
    LIGHT_FORWARD_ONLY = 3'b001,
    LIGHT_LEFT_ONLY    = 3'b010,
    LIGHT_RIGHT_ONLY   = 3'b011,
    LIGHT_GO           = 3'b100
  } light_code_e;

  // Bits 0-3 of sensor_light are junction box occupancy; 4-7 are approach demand.
  localparam int SENS_BOX_LSB = 0;
  localparam int SENS_BOX_MSB = 3;
  localparam int SENS_SB_AT_N = 4;
  localparam int SENS_EB_AT_W = 5;
  localparam int SENS_NB_AT_S = 6;
  localparam int SENS_WB_AT_E = 7;

  typedef enum logic [2:0] {
    INIT_STOP = 3'd0,
    NS_GO     = 3'd1,
    NS_CLEAR  = 3'd2,
    EW_GO     = 3'd3,
    EW_CLEAR  = 3'd4
  } phase_state_e;

endpackage

// File: rtl/phase_timer.sv
// rtl/phase_timer.sv - saturating phase counter, cleared on the cycle a controller changes state
module phase_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (cnt_q != '1) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/light_phase_sequencer.sv
// rtl/light_phase_sequencer.sv - two-phase sensor-actuated intersection light controller
// Optional registered debug_port when LIGHT_SEQ_DEBUG_PORT_EN is defined.
module light_phase_sequencer
  import traffic_light_pkg::*;
#(
  parameter logic [7:0] GREEN_MIN    = 8'd20,
  parameter logic [7:0] GREEN_MAX    = 8'd60,
  parameter logic [7:0] CLEAR_CYCLES = 8'd6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  sensor_light,
  input  logic [29:0] general_sensors,
  output logic [2:0]  outN,
  output logic [2:0]  outS,
  output logic [2:0]  outE,
  output logic [2:0]  outW
`ifdef LIGHT_SEQ_DEBUG_PORT_EN
  ,
  output logic [29:0] debug_port
`endif
);

  logic         dem_ns, dem_ew, box_busy;
  logic         ns_yield, ew_yield, clear_done;
  logic [7:0]   cnt;
  phase_state_e state_q, state_d;
  logic [2:0]   out_ns_q, out_ns_d, out_ew_q, out_ew_d;
  logic [29:0]  gen_unused_q;

  assign dem_ns   = sensor_light[SENS_SB_AT_N] | sensor_light[SENS_NB_AT_S];
  assign dem_ew   = sensor_light[SENS_EB_AT_W] | sensor_light[SENS_WB_AT_E];
  assign box_busy = |sensor_light[SENS_BOX_MSB:SENS_BOX_LSB];

  // A saturated count still satisfies every threshold, so rest-in-green yields promptly.
  assign ns_yield = dem_ew && (((cnt >= GREEN_MIN - 8'd1) && !dem_ns) ||
                               (cnt >= GREEN_MAX - 8'd1));
  assign ew_yield = dem_ns && (((cnt >= GREEN_MIN - 8'd1) && !dem_ew) ||
                               (cnt >= GREEN_MAX - 8'd1));
  assign clear_done = (cnt >= CLEAR_CYCLES - 8'd1) && !box_busy;

  phase_timer #(.W(8)) u_phase_timer (
    .clk   (clk),
    .rst   (rst),
    .clr_i (state_d != state_q),
    .cnt_o (cnt)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      INIT_STOP: if ((cnt == CLEAR_CYCLES - 8'd1) && !box_busy) state_d = NS_GO;
      NS_GO:     if (ns_yield)   state_d = NS_CLEAR;
      NS_CLEAR:  if (clear_done) state_d = EW_GO;
      EW_GO:     if (ew_yield)   state_d = EW_CLEAR;
      EW_CLEAR:  if (clear_done) state_d = NS_GO;
      default:   state_d = INIT_STOP;
    endcase
  end

  // Outputs decode the next state so the lights change on the same edge as the state.
  always_comb begin
    out_ns_d = LIGHT_STOP;
    out_ew_d = LIGHT_STOP;
    if (state_d == NS_GO) out_ns_d = LIGHT_GO;
    if (state_d == EW_GO) out_ew_d = LIGHT_GO;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= INIT_STOP;
      out_ns_q     <= LIGHT_STOP;
      out_ew_q     <= LIGHT_STOP;
      gen_unused_q <= '0;
    end else begin
      state_q      <= state_d;
      out_ns_q     <= out_ns_d;
      out_ew_q     <= out_ew_d;
      gen_unused_q <= general_sensors;
    end
  end

  assign outN = out_ns_q;
  assign outS = out_ns_q;
  assign outE = out_ew_q;
  assign outW = out_ew_q;

`ifdef LIGHT_SEQ_DEBUG_PORT_EN
  logic [7:0]  cnt_d;
  logic [29:0] debug_q;

  // Mirrors the timer's next value so debug_port lines up with the current state and count.
  assign cnt_d = (state_d != state_q) ? 8'd0 : ((cnt == 8'hFF) ? cnt : cnt + 8'd1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      debug_q <= '0;
    end else begin
      debug_q <= {8'd0, box_busy, dem_ew, dem_ns, sensor_light, cnt_d, state_d};
    end
  end

  assign debug_port = debug_q;
`endif

endmodule

// File: doc/light_phase_sequencer.md
Name: light_phase_sequencer

Overview:
- Sensor-actuated two-phase controller for one four-way intersection light.
- Alternates north/south and east/west right-of-way with a minimum and maximum green time.
- Inserts an all-stop clearance interval between phases; clearance extends while the junction box is occupied.
- Drives the four 3-bit direction codes consumed by the light instance on the map.

Parameters:
- GREEN_MIN, 8'd20, cycles a phase holds Go before it may yield to waiting cross traffic.
- GREEN_MAX, 8'd60, cycles after which a phase must yield if cross traffic is waiting.
- CLEAR_CYCLES, 8'd6, minimum all-stop cycles between phases; also the length of the post-reset all-stop.
- All three are 1..255. Required ordering: GREEN_MIN < GREEN_MAX.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-low reset
- sensor_light  input  8  per-light car sensors. Bits 0-3 are junction box occupancy. Bit 4 is a southbound car waiting at the north approach. Bit 5 is eastbound at the west. Bit 6 is northbound at the south. Bit 7 is westbound at the east.
- general_sensors  input  30  user-placed level sensors; registered but unused in the base block
- outN  output  3  code for northbound traffic
- outS  output  3  code for southbound traffic
- outE  output  3  code for eastbound traffic
- outW  output  3  code for westbound traffic

Behaviour:
- Light codes: Stop=000, Forward_only=001, Left_only=010, Right_only=011, Go=100. This block emits only Stop and Go.
- Derived signals, combinational from the current inputs:
  - dem_ns = sensor_light[4] | sensor_light[6]
  - dem_ew = sensor_light[5] | sensor_light[7]
  - box_busy = |sensor_light[3:0]
- States: INIT_STOP, NS_GO, NS_CLEAR, EW_GO, EW_CLEAR.
- Phase counter cnt is 8 bits. It clears to 0 on every state entry, increments each cycle and saturates at 255.
- Outputs are registered and take effect in the same cycle the state changes:
  - NS_GO: outN=outS=Go, outE=outW=Stop.
  - EW_GO: outE=outW=Go, outN=outS=Stop.
  - All other states: all four outputs Stop.
- Reset (rst=0, asynchronous): state=INIT_STOP, cnt=0, all outputs Stop. Reset asserted mid-phase drops all outputs to Stop immediately, with no clearance interval.
- INIT_STOP -> NS_GO when cnt == CLEAR_CYCLES-1 and !box_busy.
- NS_GO -> NS_CLEAR when dem_ew and either:
  - cnt >= GREEN_MIN-1 and !dem_ns, or
  - cnt >= GREEN_MAX-1.
- With no dem_ew, NS_GO holds indefinitely (rest-in-green). The counter saturates and the saturated value still satisfies the thresholds.
- NS_CLEAR -> EW_GO when cnt >= CLEAR_CYCLES-1 and !box_busy. While box_busy, the state holds with no upper limit.
- EW_GO -> EW_CLEAR: mirror of the NS_GO rule, with ns and ew swapped.
- EW_CLEAR -> NS_GO: same rule as NS_CLEAR.
- Simultaneous dem_ns and dem_ew: the current phase serves until GREEN_MAX, then yields.
- Neither direction receives Go in the same cycle as the opposing direction, or the cycle immediately after it. At least CLEAR_CYCLES Stop cycles always separate the two phases.
- Latency: a transition condition true in cycle t gives new outputs visible after the edge ending cycle t.

Optional Feature:
- Macro: LIGHT_SEQ_DEBUG_PORT_EN.
- When defined, the block adds output debug_port[29:0]:
  - [2:0] = state encoding
  - [10:3] = cnt
  - [18:11] = sensor_light
  - [19] = dem_ns
  - [20] = dem_ew
  - [21] = box_busy
  - [29:22] = 0
- debug_port is registered and resets to 0.
- When undefined, the port and its logic are absent. Behaviour is otherwise identical.

Decomposition:
- Shared package traffic_light_pkg holds:
  - the 3-bit light-code constants Stop..Go;
  - the sensor bit-index constants;
  - the phase state enum typedef.
- One sub-module, phase_timer: the 8-bit saturating counter with a clear-on-state-change input, reused by other light controllers.

Test Plan:
- Reset release, no sensors: all outputs Stop for 6 cycles, then outN=outS=Go. Outputs stay there for 500 cycles.
- NS_GO with sensor_light[5]=1 only: exactly 20 Go cycles, then 6 all-Stop cycles, then outE=outW=Go.
- sensor_light[5] and [4] both held high: the NS green lasts exactly 60 cycles before clearance.
- During NS_CLEAR, sensor_light[1]=1 for 15 cycles: all outputs stay Stop until 1 cycle after the bit drops. EW_GO follows with no Go overlap.
- Reset asserted mid-EW_GO: all outputs Stop in the same cycle (asynchronous). After release, the sequence restarts at INIT_STOP.
- With LIGHT_SEQ_DEBUG_PORT_EN: debug_port[2:0] tracks the state encoding and [10:3] equals cnt every cycle.
